erase_engine: RTL and testbench
===============================

// Module: erase_engine
// PURPOSE
//  Parametrised bulk-erase engine for the terminal's character buffer.
//  Accepts one erase command (end-of-line, end-of-screen, whole line, whole screen)
//  from command_handler and writes FILL_CHAR into the buffer, one cell per clock.
//  Cell addresses are computed relative to the scroll register's first_char, with
//  ring wrap-around. Sits between command_handler and char_buffer's write port.
// PARAMETERS
//  ROW_BITS   5      width of row coordinate
//  COL_BITS   7      width of column coordinate
//  ADDR_BITS  11     char buffer address width
//  ROWS       24     visible rows; ring size is ROWS*COLS
//  COLS       80     visible columns
//  FILL_CHAR  8'h20  byte written to every erased cell
// PORTS
//  clk               in   1          system clock (single clock domain)
//  reset             in   1          synchronous, active-high reset
//  cmd_valid         in   1          erase command offered
//  cmd_ready         out  1          engine can accept a command
//  cmd_mode          in   2          0=EOL, 1=EOS, 2=LINE, 3=SCREEN
//  cmd_x             in   COL_BITS   cursor column at command time
//  cmd_y             in   ROW_BITS   cursor row at command time
//  first_char        in   ADDR_BITS  current scroll offset (always < ROWS*COLS)
//  new_char          out  8          write data to char_buffer
//  new_char_address  out  ADDR_BITS  write address to char_buffer
//  new_char_wen      out  1          write enable to char_buffer
//  busy              out  1          high from SETUP through last write
//  done              out  1          one-cycle pulse after the last write
// BEHAVIOUR
//  - Reset: state=IDLE, new_char_wen=0, new_char_address=0, new_char=FILL_CHAR,
//    busy=0, done=0. cmd_ready is combinational (state==IDLE), so it is 1 after reset.
//  - Handshake: a command is accepted on the edge where cmd_valid & cmd_ready.
//    cmd_mode, clamped x/y and first_char are snapshotted; later input changes have no effect.
//  - Clamp: x = min(cmd_x, COLS-1), y = min(cmd_y, ROWS-1).
//  - Start cell (col, row) and count N:
//    - EOL:    (x, y), N = COLS-x
//    - EOS:    (x, y), N = (ROWS-y)*COLS - x
//    - LINE:   (0, y), N = COLS
//    - SCREEN: (0, 0), N = ROWS*COLS
//  - Address: a = first_char + row*COLS + col, computed at ADDR_BITS+1 width;
//    if a >= ROWS*COLS then a -= ROWS*COLS. Each following write uses a+1; a+1 == ROWS*COLS wraps to 0.
//  - FSM:
//    - IDLE  -> SETUP on accept
//    - SETUP -> WRITE: compute start address and N; no write in SETUP
//    - WRITE: one write per cycle, N cycles; -> DONE after the N-th write
//    - DONE  -> IDLE: done=1 for exactly this cycle
//  - Latency: accept at edge k; first new_char_wen at cycle k+2; last write at k+1+N;
//    done at k+2+N; cmd_ready=1 again at k+3+N.
//  - new_char_wen is high for exactly N consecutive cycles per command.
//    Every cell is written exactly once; no address repeats within a command.
//  - busy=1 in SETUP and WRITE, 0 in IDLE and DONE.
//  - cmd_valid held while not IDLE is ignored; no queueing.
//  - Reset mid-operation: next edge returns to IDLE, wen=0, no done pulse.
//    Partially erased cells are left as written.
//  - first_char changes during an erase do not affect that erase.
// TESTING
//  1. ROWS=24, COLS=80, first_char=0, EOL x=70 y=3 -> 10 writes to addr 310..319, data 0x20; done one cycle after addr 319.
//  2. first_char=1900, EOL x=10 y=0 -> 70 writes: 1910..1919 then 0..59; no address >=1920.
//  3. SCREEN, first_char=517 -> 1920 writes, each of 0..1919 exactly once; busy high throughout; one done pulse.
//  4. cmd_valid held high with a second EOL command during busy -> second accepted only after done; executes fully.
//  5. EOS x=0 y=20, reset asserted after 5 writes -> wen=0 next cycle, no done, cmd_ready=1 after reset.
//  6. first_char=0, EOL x=100 y=30 (out of range) -> clamped to (79,23): single write to addr 1919.

Source files
------------

// File: rtl/erase_engine.sv
// Bulk-erase engine: fills an EOL/EOS/LINE/SCREEN region of the character ring
// buffer with FILL_CHAR, one cell per clock, relative to the scroll offset.
module erase_engine #(
  parameter int         ROW_BITS  = 5,
  parameter int         COL_BITS  = 7,
  parameter int         ADDR_BITS = 11,
  parameter int         ROWS      = 24,
  parameter int         COLS      = 80,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_mode,
  input  logic [COL_BITS-1:0]  cmd_x,
  input  logic [ROW_BITS-1:0]  cmd_y,
  input  logic [ADDR_BITS-1:0] first_char,
  output logic [7:0]           new_char,
  output logic [ADDR_BITS-1:0] new_char_address,
  output logic                 new_char_wen,
  output logic                 busy,
  output logic                 done
);

  localparam int AW1 = ADDR_BITS + 1;
  localparam logic [AW1-1:0] RING   = AW1'(ROWS * COLS);
  localparam logic [AW1-1:0] COLS_W = AW1'(COLS);
  localparam logic [AW1-1:0] ROWS_W = AW1'(ROWS);

  localparam logic [1:0] MODE_EOL    = 2'd0;
  localparam logic [1:0] MODE_EOS    = 2'd1;
  localparam logic [1:0] MODE_LINE   = 2'd2;
  localparam logic [1:0] MODE_SCREEN = 2'd3;

  typedef enum logic [1:0] {IDLE, SETUP, WRITE, DONE} state_t;

  state_t               state, state_nxt;
  logic [1:0]           mode_q;
  logic [COL_BITS-1:0]  x_q;
  logic [ROW_BITS-1:0]  y_q;
  logic [ADDR_BITS-1:0] fc_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [AW1-1:0]       left_q;

  logic [AW1-1:0]       row, col, sum, start_n, addr_p1;
  logic [ADDR_BITS-1:0] start_a, addr_nxt;

  function automatic logic [COL_BITS-1:0] clamp_x(input logic [COL_BITS-1:0] v);
    return (int'(v) > COLS - 1) ? COL_BITS'(COLS - 1) : v;
  endfunction

  function automatic logic [ROW_BITS-1:0] clamp_y(input logic [ROW_BITS-1:0] v);
    return (int'(v) > ROWS - 1) ? ROW_BITS'(ROWS - 1) : v;
  endfunction

  // Region geometry from the snapshot; valid while in SETUP
  always_comb begin
    row     = AW1'(y_q);
    col     = AW1'(x_q);
    start_n = COLS_W - AW1'(x_q);
    case (mode_q)
      MODE_EOL:    start_n = COLS_W - AW1'(x_q);
      MODE_EOS:    start_n = (ROWS_W - AW1'(y_q)) * COLS_W - AW1'(x_q);
      MODE_LINE: begin
        col     = '0;
        start_n = COLS_W;
      end
      MODE_SCREEN: begin
        row     = '0;
        col     = '0;
        start_n = RING;
      end
      default:     start_n = COLS_W - AW1'(x_q);
    endcase
    // first_char < RING and the offset < RING, so one subtraction folds the sum
    sum      = AW1'(fc_q) + row * COLS_W + col;
    start_a  = ADDR_BITS'((sum >= RING) ? sum - RING : sum);
    addr_p1  = AW1'(addr_q) + AW1'(1);
    addr_nxt = ADDR_BITS'((addr_p1 == RING) ? '0 : addr_p1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = SETUP;
      SETUP:   state_nxt = WRITE;
      WRITE:   if (left_q == AW1'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      addr_q <= '0;
      left_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == SETUP) begin
        addr_q <= start_a;
        left_q <= start_n;
      end else if (state == WRITE) begin
        addr_q <= addr_nxt;
        left_q <= left_q - AW1'(1);
      end
    end
  end

  // Command snapshot: later input changes must not disturb a running erase
  always_ff @(posedge clk) begin
    if (state == IDLE && cmd_valid) begin
      mode_q <= cmd_mode;
      x_q    <= clamp_x(cmd_x);
      y_q    <= clamp_y(cmd_y);
      fc_q   <= first_char;
    end
  end

  assign cmd_ready        = (state == IDLE);
  assign new_char_wen     = (state == WRITE);
  assign busy             = (state == SETUP) || (state == WRITE);
  assign done             = (state == DONE);
  assign new_char         = FILL_CHAR;
  assign new_char_address = addr_q;

endmodule

// File: tb/tb_erase_engine.sv
// Scoreboard bench for erase_engine: a region/modulo reference model predicts
// every write and the done pulse with its cycle; a monitor pops and compares.
module tb_erase_engine;

  localparam int ROWS = 24;
  localparam int COLS = 80;
  localparam int RING = ROWS * COLS;

  logic        clk = 0;
  logic        reset = 1;
  logic        cmd_valid = 0;
  logic        cmd_ready;
  logic [1:0]  cmd_mode = 0;
  logic [6:0]  cmd_x = 0;
  logic [4:0]  cmd_y = 0;
  logic [10:0] first_char = 0;
  logic [7:0]  new_char;
  logic [10:0] new_char_address;
  logic        new_char_wen;
  logic        busy;
  logic        done;

  erase_engine dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .first_char(first_char),
    .new_char(new_char), .new_char_address(new_char_address),
    .new_char_wen(new_char_wen), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit is_done;
    int addr;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: region start cell and length, then modulo walk of the ring
  task automatic push_cmd(input int mode, input int x, input int y, input int fc,
                          input int k, input int limit);
    int xc, yc, row, col, n, a0;
    xc = (x > COLS - 1) ? COLS - 1 : x;
    yc = (y > ROWS - 1) ? ROWS - 1 : y;
    case (mode)
      0:       begin row = yc; col = xc; n = COLS - xc; end
      1:       begin row = yc; col = xc; n = (ROWS - yc) * COLS - xc; end
      2:       begin row = yc; col = 0;  n = COLS; end
      default: begin row = 0;  col = 0;  n = RING; end
    endcase
    a0 = (fc + row * COLS + col) % RING;
    for (int j = 0; j < n && j < limit; j++)
      q.push_back('{cyc: k + 1 + j, is_done: 1'b0, addr: (a0 + j) % RING});
    if (limit >= n)
      q.push_back('{cyc: k + 1 + n, is_done: 1'b1, addr: 0});
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (new_char_wen || done) begin
      if (q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        e = q.pop_front();
        chk("ev_kind_done", int'(done), int'(e.is_done));
        chk("ev_cycle", cyc, e.cyc);
        if (!e.is_done) begin
          chk("wr_addr", int'(new_char_address), e.addr);
          chk("wr_data", int'(new_char), 32'h20);
          chk("wr_busy", int'(busy), 1);
        end else begin
          chk("done_busy", int'(busy), 0);
          chk("done_wen", int'(new_char_wen), 0);
        end
      end
    end else if (q.size() > 0 && q[0].cyc < cyc) begin
      chk("missing_output", 0, 1);
      void'(q.pop_front());
    end
  end

  // Offer a command; junk is driven on the inputs while the engine is busy
  task automatic issue(input int mode, input int x, input int y, input int fc,
                       input bit keep, input int limit, output int k);
    int waitc = 0;
    @(negedge clk);
    while (!cmd_ready) begin
      waitc++;
      if (waitc > 5000) begin
        $display("FAIL ready_timeout: got 0, expected 1 (cycle %0d)", cyc);
        $fatal(1, "engine never returned to idle");
      end
      cmd_mode   = 2'($urandom);
      cmd_x      = 7'($urandom);
      cmd_y      = 5'($urandom);
      first_char = 11'($urandom_range(0, RING - 1));
      @(negedge clk);
    end
    cmd_mode   = 2'(mode);
    cmd_x      = 7'(x);
    cmd_y      = 5'(y);
    first_char = 11'(fc);
    cmd_valid  = 1;
    k = cyc + 1;
    push_cmd(mode, x, y, fc, k, limit);
    @(negedge clk);
    chk("setup_busy", int'(busy), 1);
    chk("setup_wen", int'(new_char_wen), 0);
    chk("setup_ready", int'(cmd_ready), 0);
    first_char = 11'($urandom_range(0, RING - 1));
    cmd_x      = 7'($urandom);
    if (!keep) cmd_valid = 0;
  endtask

  initial begin
    int k, waitc, mode;
    bit screen_done;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_wen", int'(new_char_wen), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_addr", int'(new_char_address), 0);
    chk("rst_data", int'(new_char), 32'h20);
    reset = 0;

    issue(0, 70, 3, 0, 0, 1 << 30, k);       // EOL, 310..319
    issue(0, 10, 0, 1900, 0, 1 << 30, k);    // EOL across the ring seam
    issue(3, 0, 0, 517, 0, 1 << 30, k);      // whole screen
    issue(0, 5, 7, 100, 1, 1 << 30, k);      // valid held through busy
    issue(0, 40, 2, 33, 0, 1 << 30, k);
    issue(0, 100, 30, 0, 0, 1 << 30, k);     // clamped to (79,23) -> 1919
    issue(2, 50, 12, 1800, 0, 1 << 30, k);

    // Reset after five writes of an EOS erase
    issue(1, 0, 20, 0, 0, 5, k);
    repeat (5) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("midrst_wen", int'(new_char_wen), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ready", int'(cmd_ready), 1);
    reset = 0;

    screen_done = 0;
    for (int i = 0; i < 16; i++) begin
      mode = $urandom_range(0, 3);
      if (mode == 3 && screen_done) mode = 2;
      if (mode == 3) screen_done = 1;
      issue(mode, $urandom_range(0, 127), $urandom_range(0, 31),
            $urandom_range(0, RING - 1), 1'($urandom), 1 << 30, k);
    end
    cmd_valid = 0;

    waitc = 0;
    while (q.size() != 0 && waitc < 5000) begin
      @(negedge clk);
      waitc++;
    end
    chk("drain_queue", q.size(), 0);
    repeat (3) @(negedge clk);
    chk("final_ready", int'(cmd_ready), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
